// File: rtl/matmul_pkg.sv
// Shared types and default sizing for the matrix-multiply sequencer.
package matmul_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } matmul_state_t;

    localparam int unsigned DEF_DATA_WIDTH  = 32;
    localparam int unsigned DEF_VECTOR_SIZE = 8;
    localparam int unsigned DEF_IDX_WIDTH   = $clog2(DEF_VECTOR_SIZE);
    localparam int unsigned DEF_ADDR_WIDTH  = 2 * DEF_IDX_WIDTH;

endpackage

// File: rtl/matmul_mac.sv
// Stage 1/2 multiply-accumulate: folds one x*y product per valid beat and
// emits a z write when the beat carries the last-k tag.
module matmul_mac #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_valid,
    input  logic                  i_first,
    input  logic                  i_last,
    input  logic [ADDR_WIDTH-1:0] i_zaddr,
    input  logic [DATA_WIDTH-1:0] i_x,
    input  logic [DATA_WIDTH-1:0] i_y,
    output logic                  o_z_wr_en,
    output logic [ADDR_WIDTH-1:0] o_z_wr_addr,
    output logic [DATA_WIDTH-1:0] o_z_din
);

    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] w_prod;
    logic [DATA_WIDTH-1:0] w_acc_next;
    logic                  r_z_wr_en;
    logic [ADDR_WIDTH-1:0] r_z_wr_addr;
    logic [DATA_WIDTH-1:0] r_z_din;

    // Product and sum wrap modulo 2^DATA_WIDTH.
    assign w_prod     = i_x * i_y;
    assign w_acc_next = i_first ? w_prod : r_acc + w_prod;

    // Accumulator and registered z write port.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_acc       <= '0;
            r_z_wr_en   <= 1'b0;
            r_z_wr_addr <= '0;
            r_z_din     <= '0;
        end else begin
            r_z_wr_en <= i_valid && i_last;
            if (i_valid) begin
                r_acc <= w_acc_next;
            end
            if (i_valid && i_last) begin
                r_z_din     <= w_acc_next;
                r_z_wr_addr <= i_zaddr;
            end
        end
    end

    assign o_z_wr_en   = r_z_wr_en;
    assign o_z_wr_addr = r_z_wr_addr;
    assign o_z_din     = r_z_din;

endmodule

// File: rtl/matmul_ctrl.sv
// Triple-loop sequencer for the matrix-multiply engine: issues one x/y read
// pair per cycle, tags each beat for the MAC, and flags completion.
module matmul_ctrl
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned VECTOR_SIZE = DEF_VECTOR_SIZE
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] x_rd_addr,
    input  logic [DATA_WIDTH-1:0] x_dout,
    output logic [ADDR_WIDTH-1:0] y_rd_addr,
    input  logic [DATA_WIDTH-1:0] y_dout,
    output logic [ADDR_WIDTH-1:0] z_wr_addr,
    output logic                  z_wr_en,
    output logic [DATA_WIDTH-1:0] z_din
);

    localparam int unsigned IDX_W = $clog2(VECTOR_SIZE);
    localparam int unsigned CNT_W = 3 * IDX_W;

    if (VECTOR_SIZE < 2 || (VECTOR_SIZE & (VECTOR_SIZE - 1)) != 0) begin : g_bad_size
        $error("matmul_ctrl: VECTOR_SIZE must be a power of two >= 2");
    end
    if (ADDR_WIDTH != 2 * IDX_W) begin : g_bad_addr
        $error("matmul_ctrl: ADDR_WIDTH must equal 2*log2(VECTOR_SIZE)");
    end

    matmul_state_t r_state, w_state_next;
    // {i, j, k} packed so a single increment walks k fastest, then j, then i.
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_done, w_done_next;
    logic [IDX_W-1:0] w_i, w_j, w_k;

    logic                  r_s1_valid;
    logic                  r_s1_first;
    logic                  r_s1_last;
    logic [ADDR_WIDTH-1:0] r_s1_zaddr;
    logic                  w_z_wr_en;

    assign w_k = r_cnt[IDX_W-1:0];
    assign w_j = r_cnt[2*IDX_W-1:IDX_W];
    assign w_i = r_cnt[CNT_W-1:2*IDX_W];

    // Read addresses come straight off the counter flops.
    assign x_rd_addr = {w_i, w_k};
    assign y_rd_addr = {w_k, w_j};
    assign done      = r_done;
    assign z_wr_en   = w_z_wr_en;

    // Next-state, counter and done logic.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_done_next  = r_done;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (start) begin
                    w_state_next = S_RUN;
                    w_done_next  = 1'b0;
                end
            end
            S_RUN: begin
                w_cnt_next = r_cnt + CNT_W'(1);
                if (&r_cnt) begin
                    w_state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // The only write seen in flush is the final one; done lands
                // on the edge where z BRAM captures it.
                if (w_z_wr_en) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // FSM, counter and done registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_done  <= w_done_next;
        end
    end

    // Stage-1 tags, aligned with the BRAM read data of the same issue.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_zaddr <= '0;
        end else begin
            r_s1_valid <= (r_state == S_RUN);
            r_s1_first <= (w_k == '0);
            r_s1_last  <= (&w_k);
            r_s1_zaddr <= {w_i, w_j};
        end
    end

    matmul_mac #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mac (
        .clock      (clock),
        .reset      (reset),
        .i_valid    (r_s1_valid),
        .i_first    (r_s1_first),
        .i_last     (r_s1_last),
        .i_zaddr    (r_s1_zaddr),
        .i_x        (x_dout),
        .i_y        (y_dout),
        .o_z_wr_en  (w_z_wr_en),
        .o_z_wr_addr(z_wr_addr),
        .o_z_din    (z_din)
    );

endmodule

// File: tb/tb_matmul_ctrl.sv
// Directed bench for matmul_ctrl with behavioural x/y/z BRAMs.
module tb_matmul_ctrl;
    import matmul_pkg::*;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int N  = 8;
    localparam int NE = N * N;
    localparam int LAT = N * N * N + 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          done;
    logic [AW-1:0] x_rd_addr, y_rd_addr, z_wr_addr;
    logic [DW-1:0] x_dout, y_dout, z_din;
    logic          z_wr_en;

    logic [DW-1:0] x_mem [NE];
    logic [DW-1:0] y_mem [NE];
    logic [DW-1:0] z_mem [NE];
    logic [DW-1:0] z_exp [NE];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_pulse = 0;
    int n_order_err = 0;
    int last_addr = -1;
    int lat;

    always #5 clock = ~clock;

    matmul_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .VECTOR_SIZE(N)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .done     (done),
        .x_rd_addr(x_rd_addr),
        .x_dout   (x_dout),
        .y_rd_addr(y_rd_addr),
        .y_dout   (y_dout),
        .z_wr_addr(z_wr_addr),
        .z_wr_en  (z_wr_en),
        .z_din    (z_din)
    );

    always @(posedge clock) cyc <= cyc + 1;

    // Registered-read BRAMs and z write capture.
    always @(posedge clock) begin
        x_dout <= x_mem[x_rd_addr];
        y_dout <= y_mem[y_rd_addr];
        if (z_wr_en) z_mem[z_wr_addr] <= z_din;
    end

    // Pulse counter and ascending-address monitor.
    always @(posedge clock) begin
        if (z_wr_en) begin
            if (int'(z_wr_addr) <= last_addr) n_order_err++;
            last_addr = int'(z_wr_addr);
            n_pulse++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_z(input string tag);
        for (int a = 0; a < NE; a++) begin
            check($sformatf("%s_z[%0d]", tag, a), z_mem[a], z_exp[a]);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_wen"}, 32'(z_wr_en), 32'd0);
        check({tag, "_xa"}, 32'(x_rd_addr), 32'd0);
        check({tag, "_ya"}, 32'(y_rd_addr), 32'd0);
        check({tag, "_za"}, 32'(z_wr_addr), 32'd0);
        check({tag, "_zd"}, z_din, 32'd0);
        check({tag, "_st"}, 32'(dut.r_state), 32'(S_IDLE));
    endtask

    // Reference product for randomly filled matrices.
    task automatic model_z();
        logic [DW-1:0] s;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = '0;
                for (int k = 0; k < N; k++) s = s + x_mem[i*N+k] * y_mem[k*N+j];
                z_exp[i*N+j] = s;
            end
        end
    endtask

    // Start a run and follow it to done (or abort by reset at reset_at).
    task automatic run_mm(input string tag, input bit b2b, input int restart_at,
                          input int reset_at, output int lat_o);
        int e0;
        int t;
        int p;
        n_pulse = 0;
        n_order_err = 0;
        last_addr = -1;
        if (!b2b) @(negedge clock);
        start = 1'b1;
        e0 = cyc + 1;
        @(negedge clock);
        start = 1'b0;
        lat_o = 5000;
        for (int b = 0; b < 2000; b++) begin
            t = cyc - e0;
            if (done) begin
                lat_o = t;
                break;
            end
            start = (restart_at > 0 && t == restart_at - 1);
            if (reset_at > 0 && t == reset_at) begin
                reset = 1'b0;
                #1;
                check_outputs_zero({tag, "_arst"});
                p = n_pulse;
                repeat (5) @(negedge clock);
                check({tag, "_arst_nowr"}, 32'(n_pulse), 32'(p));
                reset = 1'b1;
                lat_o = 0;
                return;
            end
            if (t == 0) check({tag, "_done_clr"}, 32'(done), 32'd0);
            if (t == 1) begin
                check({tag, "_xa1"}, 32'(x_rd_addr), 32'd1);
                check({tag, "_ya1"}, 32'(y_rd_addr), 32'd8);
            end
            if (t == 9) begin
                check({tag, "_xa9"}, 32'(x_rd_addr), 32'd1);
                check({tag, "_ya9"}, 32'(y_rd_addr), 32'd9);
                check({tag, "_wen9"}, 32'(z_wr_en), 32'd1);
                check({tag, "_za9"}, 32'(z_wr_addr), 32'd0);
            end
            if (t == 10) check({tag, "_wen10"}, 32'(z_wr_en), 32'd0);
            if (t == LAT - 1) check({tag, "_done_early"}, 32'(done), 32'd0);
            @(negedge clock);
        end
        start = 1'b0;
        check({tag, "_lat"}, 32'(lat_o), 32'(LAT));
        check({tag, "_pulses"}, 32'(n_pulse), 32'(NE));
        check({tag, "_order"}, 32'(n_order_err), 32'd0);
    endtask

    task automatic fill_const(input logic [DW-1:0] xv, input logic [DW-1:0] yv,
                              input logic [DW-1:0] zv);
        for (int a = 0; a < NE; a++) begin
            x_mem[a] = xv;
            y_mem[a] = yv;
            z_exp[a] = zv;
        end
    endtask

    initial begin
        for (int a = 0; a < NE; a++) begin
            x_mem[a] = '0;
            y_mem[a] = '0;
            z_mem[a] = '0;
        end
        repeat (3) @(negedge clock);
        check_outputs_zero("rst");
        reset = 1'b1;
        @(negedge clock);

        // Identity x, y = k*8+j: z[a] = a.
        for (int a = 0; a < NE; a++) begin
            x_mem[a] = ((a / N) == (a % N)) ? 32'd1 : 32'd0;
            y_mem[a] = 32'(a);
            z_exp[a] = 32'(a);
        end
        run_mm("ident", 1'b0, 0, 0, lat);
        check_z("ident");

        fill_const(32'd1, 32'd1, 32'd8);
        run_mm("ones", 1'b0, 0, 0, lat);
        check_z("ones");

        fill_const(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd8);
        run_mm("neg1", 1'b0, 0, 0, lat);
        check_z("neg1");

        fill_const(32'h8000_0000, 32'd2, 32'd0);
        run_mm("wrap", 1'b0, 0, 0, lat);
        check_z("wrap");

        // Random data with a stray start mid-run.
        for (int a = 0; a < NE; a++) begin
            x_mem[a] = $urandom;
            y_mem[a] = $urandom;
        end
        model_z();
        run_mm("rnd", 1'b0, 100, 0, lat);
        check_z("rnd");

        // Reset abort, then a clean rerun on fresh random data.
        for (int a = 0; a < NE; a++) begin
            x_mem[a] = $urandom;
            y_mem[a] = $urandom;
        end
        model_z();
        run_mm("abort", 1'b0, 0, 200, lat);
        @(negedge clock);
        run_mm("rerun", 1'b0, 0, 0, lat);
        check_z("rerun");

        // Back-to-back: start in the first cycle done is visible.
        check("b2b_done_pre", 32'(done), 32'd1);
        for (int a = 0; a < NE; a++) begin
            x_mem[a] = ((a / N) == (a % N)) ? 32'd2 : 32'd0;
            y_mem[a] = 32'(a);
            z_exp[a] = 32'(2 * a);
        end
        run_mm("b2b", 1'b1, 0, 0, lat);
        check_z("b2b");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
